// File: rtl/regfile_writeback_pkg.sv
// Shared widths and entry layout for the register-file writeback front end.
// The struct is the default-width view of one pending write.
package regfile_writeback_pkg;

    localparam int WB_AW    = 6;
    localparam int WB_DW    = 32;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over a list of candidate pending writes.
// Candidate 0 is the youngest; higher indices are progressively older.
module wb_fwd_match
    import regfile_writeback_pkg::*;
#(
    parameter int N  = WB_DEPTH + 1,
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
) (
    input  logic [N-1:0]         valid_i,
    input  logic [N-1:0][AW-1:0] rd_i,
    input  logic [N-1:0][DW-1:0] data_i,
    input  logic [AW-1:0]        addr_i,
    output logic                 hit_o,
    output logic [DW-1:0]        fwd_o
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        hit_o = 1'b0;
        fwd_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid_i[k] && (rd_i[k] == addr_i)) begin
                hit_o = 1'b1;
                fwd_o = data_i[k];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback front end: arbitrates ALU/load results into an in-order queue,
// drains one write per cycle to the register file, and forwards pending data.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_rd,
    input  logic [DW-1:0]          alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [AW-1:0]          mem_rd,
    input  logic [DW-1:0]          mem_data,
    output logic                   mem_ready,
    output logic [AW-1:0]          rd,
    output logic [DW-1:0]          dataIn,
    output logic                   write_signal,
    input  logic [AW-1:0]          rs,
    input  logic [AW-1:0]          rt,
    output logic                   rs_hit,
    output logic [DW-1:0]          rs_fwd,
    output logic                   rt_hit,
    output logic [DW-1:0]          rt_fwd,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NS = DEPTH + 1;
    localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_FREE_C = CW'(DEPTH - 1);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        queue_q [DEPTH];
    entry_t        out_q, out_d;
    logic          we_q, we_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] alu_slot;
    logic [CW-1:0] count_q, count_d;
    logic          mem_push, alu_push, pop;

    // Readies look only at the registered count; a same-cycle pop earns no credit.
    always_comb begin
        mem_ready = !rst && (count_q < FULL_C);
        alu_ready = !rst && ((count_q < ONE_FREE_C) ||
                             ((count_q < FULL_C) && !mem_valid));
        mem_push  = mem_valid && mem_ready;
        alu_push  = alu_valid && alu_ready;
        pop       = (count_q != '0);
        alu_slot  = wr_ptr_q + PW'(mem_push);
        wr_ptr_d  = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        we_d      = pop;
        out_d     = out_q;
        if (pop) begin
            out_d = queue_q[rd_ptr_q];
        end
    end

    // The load entry lands first so it is the older of a same-cycle pair.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            queue_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
        end
        if (alu_push) begin
            queue_q[alu_slot] <= '{rd: alu_rd, data: alu_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= 1'b0;
            out_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            we_q     <= we_d;
            out_q    <= out_d;
        end
    end

    assign rd           = out_q.rd;
    assign dataIn       = out_q.data;
    assign write_signal = we_q;
    assign pending      = count_q;

    logic [NS-1:0]         cand_valid;
    logic [NS-1:0][AW-1:0] cand_rd;
    logic [NS-1:0][DW-1:0] cand_data;

    // Candidates ordered by age: 0 is the tail entry, DEPTH is the output stage.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PW-1:0] slot;
        assign slot           = wr_ptr_q - PW'(gi + 1);
        assign cand_valid[gi] = (count_q > CW'(gi));
        assign cand_rd[gi]    = queue_q[slot].rd;
        assign cand_data[gi]  = queue_q[slot].data;
    end

    assign cand_valid[DEPTH] = we_q;
    assign cand_rd[DEPTH]    = out_q.rd;
    assign cand_data[DEPTH]  = out_q.data;

    wb_fwd_match #(
        .N  (NS),
        .AW (AW),
        .DW (DW)
    ) u_rs_match (
        .valid_i (cand_valid),
        .rd_i    (cand_rd),
        .data_i  (cand_data),
        .addr_i  (rs),
        .hit_o   (rs_hit),
        .fwd_o   (rs_fwd)
    );

    wb_fwd_match #(
        .N  (NS),
        .AW (AW),
        .DW (DW)
    ) u_rt_match (
        .valid_i (cand_valid),
        .rd_i    (cand_rd),
        .data_i  (cand_data),
        .addr_i  (rt),
        .hit_o   (rt_hit),
        .fwd_o   (rt_fwd)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: each task drives one scenario and
// checks hand-computed expectations inline.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [5:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [5:0]  rd;
    logic [31:0] dataIn;
    logic        write_signal;
    logic [5:0]  rs, rt;
    logic        rs_hit, rt_hit;
    logic [31:0] rs_fwd, rt_fwd;
    logic [2:0]  pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rd           (rd),
        .dataIn       (dataIn),
        .write_signal (write_signal),
        .rs           (rs),
        .rt           (rt),
        .rs_hit       (rs_hit),
        .rs_fwd       (rs_fwd),
        .rt_hit       (rt_hit),
        .rt_fwd       (rt_fwd),
        .pending      (pending)
    );

    always @(negedge clk) begin
        if (!rst && write_signal) $display("[TB] write rd=%0d data=%h", rd, dataIn);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); rs = '0; rt = '0;
        alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
        cyc(); cyc();
        mem_valid = 1'b1; alu_valid = 1'b1; #1;
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
        cyc();
        tests++; if (write_signal !== 1'b0) begin fails++; $display("FAIL reset_ws: got %b want 0", write_signal); end
        tests++; if (pending !== 3'd0) begin fails++; $display("FAIL reset_pending: got %0d want 0", pending); end
        tests++; if (rd !== 6'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", rd); end
        tests++; if (dataIn !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", dataIn); end
        idle(); rst = 1'b0;
        cyc();
        tests++; if (pending !== 3'd0) begin fails++; $display("FAIL reset_release_pending: got %0d want 0", pending); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 6'd5; alu_data = 32'hDEADBEEF; #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", alu_ready); end
        cyc(); idle(); rs = 6'd5; #1;
        tests++; if (pending !== 3'd1) begin fails++; $display("FAIL single_pending: got %0d want 1", pending); end
        tests++; if (write_signal !== 1'b0) begin fails++; $display("FAIL single_ws_early: got %b want 0", write_signal); end
        tests++; if (rs_hit !== 1'b1 || rs_fwd !== 32'hDEADBEEF) begin fails++; $display("FAIL single_qfwd: got %b/%h want 1/deadbeef", rs_hit, rs_fwd); end
        cyc();
        tests++; if (write_signal !== 1'b1) begin fails++; $display("FAIL single_ws: got %b want 1", write_signal); end
        tests++; if (rd !== 6'd5 || dataIn !== 32'hDEADBEEF) begin fails++; $display("FAIL single_out: got %0d/%h want 5/deadbeef", rd, dataIn); end
        tests++; if (pending !== 3'd0) begin fails++; $display("FAIL single_drained: got %0d want 0", pending); end
        cyc();
        tests++; if (write_signal !== 1'b0) begin fails++; $display("FAIL single_ws_once: got %b want 0", write_signal); end
        tests++; if (rd !== 6'd5 || dataIn !== 32'hDEADBEEF) begin fails++; $display("FAIL single_hold: got %0d/%h want 5/deadbeef", rd, dataIn); end
    endtask

    task automatic test_simultaneous();
        mem_valid = 1'b1; mem_rd = 6'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 6'd4; alu_data = 32'h22; #1;
        tests++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin fails++; $display("FAIL sim_ready: got %b%b want 11", mem_ready, alu_ready); end
        cyc(); idle();
        tests++; if (pending !== 3'd2) begin fails++; $display("FAIL sim_pending: got %0d want 2", pending); end
        cyc();
        tests++; if (write_signal !== 1'b1 || rd !== 6'd3 || dataIn !== 32'h11) begin fails++; $display("FAIL sim_first: got %b/%0d/%h want 1/3/11", write_signal, rd, dataIn); end
        cyc();
        tests++; if (write_signal !== 1'b1 || rd !== 6'd4 || dataIn !== 32'h22) begin fails++; $display("FAIL sim_second: got %b/%0d/%h want 1/4/22", write_signal, rd, dataIn); end
        cyc();
        tests++; if (write_signal !== 1'b0) begin fails++; $display("FAIL sim_end: got %b want 0", write_signal); end
    endtask

    task automatic test_full_priority();
        logic [5:0]  exp_rd [6];
        logic [2:0]  exp_pend [7];
        mem_valid = 1'b1; mem_rd = 6'd10; mem_data = 32'h100;
        alu_valid = 1'b1; alu_rd = 6'd11; alu_data = 32'h101;
        cyc();
        tests++; if (pending !== 3'd2) begin fails++; $display("FAIL full_p2: got %0d want 2", pending); end
        mem_rd = 6'd12; mem_data = 32'h102; alu_rd = 6'd13; alu_data = 32'h103; #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL full_alu_two_free: got %b want 1", alu_ready); end
        cyc();
        tests++; if (pending !== 3'd3) begin fails++; $display("FAIL full_p3: got %0d want 3", pending); end
        tests++; if (write_signal !== 1'b1 || rd !== 6'd10) begin fails++; $display("FAIL full_w10: got %b/%0d want 1/10", write_signal, rd); end
        mem_rd = 6'd14; mem_data = 32'h104; alu_rd = 6'd15; alu_data = 32'h105; #1;
        tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL full_mem_prio: got %b want 1", mem_ready); end
        tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL full_alu_stall: got %b want 0", alu_ready); end
        cyc();
        mem_valid = 1'b0; #1;
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL full_alu_resume: got %b want 1", alu_ready); end
        cyc(); idle();
        exp_rd = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd15};
        exp_pend = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        // At this point rd=11 (after C) was already replaced by 12 (after D).
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (write_signal !== 1'b1 || rd !== exp_rd[i] || dataIn !== 32'h100 + 32'(exp_rd[i] - 6'd10) || pending !== exp_pend[i])
                begin fails++; $display("FAIL full_drain%0d: got %b/%0d/%h/%0d want 1/%0d/%h/%0d", i, write_signal, rd, dataIn, pending, exp_rd[i], 32'h100 + 32'(exp_rd[i] - 6'd10), exp_pend[i]); end
            cyc();
        end
        tests++; if (write_signal !== 1'b0) begin fails++; $display("FAIL full_end: got %b want 0", write_signal); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 6'(i); alu_data = 32'hC0 + 32'(i);
            cyc();
            tests++; if (pending !== 3'd1) begin fails++; $display("FAIL b2b_pending%0d: got %0d want 1", i, pending); end
            if (i > 0) begin
                tests++;
                if (write_signal !== 1'b1 || rd !== 6'(i - 1) || dataIn !== 32'hC0 + 32'(i - 1))
                    begin fails++; $display("FAIL b2b_out%0d: got %b/%0d/%h want 1/%0d/%h", i, write_signal, rd, dataIn, i - 1, 32'hC0 + 32'(i - 1)); end
            end
        end
        idle(); cyc();
        tests++; if (write_signal !== 1'b1 || rd !== 6'd3 || dataIn !== 32'hC3) begin fails++; $display("FAIL b2b_last: got %b/%0d/%h want 1/3/c3", write_signal, rd, dataIn); end
        cyc();
        tests++; if (write_signal !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b want 0", write_signal); end
    endtask

    task automatic test_fwd_youngest();
        rs = 6'd7; rt = 6'd8;
        mem_valid = 1'b1; mem_rd = 6'd7; mem_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 6'd7; alu_data = 32'hB;
        cyc(); idle(); #1;
        tests++; if (rs_hit !== 1'b1 || rs_fwd !== 32'hB) begin fails++; $display("FAIL fwdy_queue: got %b/%h want 1/b", rs_hit, rs_fwd); end
        tests++; if (rt_hit !== 1'b0 || rt_fwd !== 32'h0) begin fails++; $display("FAIL fwdy_miss: got %b/%h want 0/0", rt_hit, rt_fwd); end
        cyc();
        tests++; if (write_signal !== 1'b1 || dataIn !== 32'hA) begin fails++; $display("FAIL fwdy_wA: got %b/%h want 1/a", write_signal, dataIn); end
        tests++; if (rs_hit !== 1'b1 || rs_fwd !== 32'hB) begin fails++; $display("FAIL fwdy_outA: got %b/%h want 1/b", rs_hit, rs_fwd); end
        rt = 6'd7; #1;
        tests++; if (rt_hit !== 1'b1 || rt_fwd !== 32'hB) begin fails++; $display("FAIL fwdy_same: got %b/%h want 1/b", rt_hit, rt_fwd); end
        cyc();
        tests++; if (write_signal !== 1'b1 || dataIn !== 32'hB) begin fails++; $display("FAIL fwdy_wB: got %b/%h want 1/b", write_signal, dataIn); end
        tests++; if (rs_hit !== 1'b1 || rs_fwd !== 32'hB) begin fails++; $display("FAIL fwdy_outB: got %b/%h want 1/b", rs_hit, rs_fwd); end
        cyc();
        tests++; if (rs_hit !== 1'b0 || rs_fwd !== 32'h0) begin fails++; $display("FAIL fwdy_clear: got %b/%h want 0/0", rs_hit, rs_fwd); end
    endtask

    task automatic test_out_fwd();
        rs = 6'd0; rt = 6'd9;
        alu_valid = 1'b1; alu_rd = 6'd9; alu_data = 32'h55;
        cyc(); idle(); #1;
        tests++; if (rt_hit !== 1'b1 || rt_fwd !== 32'h55) begin fails++; $display("FAIL ofwd_queue: got %b/%h want 1/55", rt_hit, rt_fwd); end
        tests++; if (rs_hit !== 1'b0) begin fails++; $display("FAIL ofwd_rs_miss: got %b want 0", rs_hit); end
        cyc();
        tests++; if (write_signal !== 1'b1 || rt_hit !== 1'b1 || rt_fwd !== 32'h55) begin fails++; $display("FAIL ofwd_stage: got %b/%b/%h want 1/1/55", write_signal, rt_hit, rt_fwd); end
        cyc();
        tests++; if (rt_hit !== 1'b0) begin fails++; $display("FAIL ofwd_clear: got %b want 0", rt_hit); end
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_rd = 6'd20; mem_data = 32'h200;
        alu_valid = 1'b1; alu_rd = 6'd21; alu_data = 32'h201;
        cyc();
        mem_rd = 6'd22; mem_data = 32'h202; alu_rd = 6'd23; alu_data = 32'h203;
        cyc(); idle(); rs = 6'd21; #1;
        tests++; if (pending !== 3'd3 || write_signal !== 1'b1) begin fails++; $display("FAIL rmid_pre: got %0d/%b want 3/1", pending, write_signal); end
        rst = 1'b1; #1;
        tests++; if (write_signal !== 1'b0 || pending !== 3'd0) begin fails++; $display("FAIL rmid_async: got %b/%0d want 0/0", write_signal, pending); end
        tests++; if (rd !== 6'd0 || dataIn !== 32'd0) begin fails++; $display("FAIL rmid_out: got %0d/%h want 0/0", rd, dataIn); end
        tests++; if (rs_hit !== 1'b0) begin fails++; $display("FAIL rmid_fwd: got %b want 0", rs_hit); end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            tests++; if (write_signal !== 1'b0 || pending !== 3'd0) begin fails++; $display("FAIL rmid_quiet%0d: got %b/%0d want 0/0", i, write_signal, pending); end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_full_priority();
        test_back_to_back();
        test_fwd_youngest();
        test_out_fwd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end for the 64x32 register file.
- Accepts writeback results from the ALU path and the memory-load path over valid/ready handshakes and buffers them in a small in-order queue.
- Drains one entry per cycle onto the register file write port (rd, dataIn, write_signal).
- Provides a forwarding lookup so decode-stage reads of rs/rt see writes that are still pending.

Parameters:
- DEPTH, 4, pending-write queue entries (power of two, >=2)
- AW, 6, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- mem_valid  in  1  load writeback request
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load request accepted this cycle when high with mem_valid
- rd  out  AW  register file write address (registered)
- dataIn  out  DW  register file write data (registered)
- write_signal  out  1  register file write enable (registered)
- rs  in  AW  lookup address A
- rt  in  AW  lookup address B
- rs_hit  out  1  a pending write to rs exists
- rs_fwd  out  DW  youngest pending data for rs
- rt_hit  out  1  a pending write to rt exists
- rt_fwd  out  DW  youngest pending data for rt
- pending  out  log2(DEPTH)+1  queued entry count (excludes output stage)

Behaviour:
- Reset (async, any time): count=0, pointers=0, write_signal=0, rd=0, dataIn=0. Queue contents are discarded; any in-flight request is dropped. Readies are 0 while rst is high.
- Ready depends on registered count only; no credit for a same-cycle pop.
  - mem_ready = (count < DEPTH)
  - alu_ready = (count < DEPTH-1) | (count < DEPTH & !mem_valid)
- Arbitration: mem has priority. When only one slot is free and both are valid, mem is accepted and alu is stalled.
- Push order: when both are accepted in the same cycle, the mem entry is enqueued first (older), then the alu entry.
- Drain: each cycle with count>0, pop the head into the output stage and set write_signal=1 the next cycle. With count=0, write_signal=0 next cycle and rd/dataIn hold their last values.
- Latency: a request accepted at edge N into an empty queue appears on rd/dataIn with write_signal=1 after edge N+1. Exactly one cycle of write_signal per accepted request, in acceptance order.
- count_next = count + pushes - pop, with pushes in 0..2 and pop in 0..1. Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - Search space: all valid queue entries plus the output stage while write_signal=1. The output stage is included because the register file read in the same edge returns the old value.
  - The youngest match wins, in order: alu-in-same-cycle is not included (only stored entries), then queue tail toward head, then the output stage.
  - No match: hit=0, fwd=0.
  - rs and rt are independent; rs==rt gives identical results.
- Address 0 is an ordinary register; no special casing.
- Duplicate rd entries in the queue are legal. All are written in order, so the final register file value is the youngest.

Decomposition:
- Shared package: AW/DW constants and a wb_entry struct {rd, data}.
- One natural sub-module: wb_fwd_match, the parameterised youngest-match search, instantiated twice (rs, rt).
- Queue and arbitration stay inline.

Test Plan:
- Reset mid-drain: enqueue 3 entries, assert rst for 1 cycle -> write_signal=0, pending=0 immediately; no later writes.
- Single ALU write: alu rd=5 data=0xDEADBEEF into empty queue -> one cycle later rd=5, dataIn=0xDEADBEEF, write_signal=1 for exactly 1 cycle.
- Simultaneous requests: mem rd=3/0x11 and alu rd=4/0x22 same cycle, empty queue -> both accepted; writes appear in order rd=3 then rd=4 on consecutive cycles.
- Full and priority: block drain via back-to-back pushes until pending=DEPTH-1, both valid -> mem_ready=1, alu_ready=0; at pending=DEPTH both readies are 0; the stalled alu is accepted after a pop.
- Forwarding youngest: queue rd=7/0xA then rd=7/0xB, rs=7 -> rs_hit=1, rs_fwd=0xB. While 0xA is in the output stage and 0xB is drained, hit holds until the 0xB write cycle ends, then rs_hit=0.
- Output-stage forward: single write rd=9/0x55, rt=9 during its write_signal cycle -> rt_hit=1, rt_fwd=0x55; the next cycle rt_hit=0.
